load_store_unit: RTL and testbench

Memory-stage load/store unit that executes the memory requests produced by the instruction decoder: `mem_read`, `mem_write`, `mem_width` and the load-unsigned bit. It sits between the MEM pipeline stage and the data-memory bus. It does the following:

- aligns store data and generates byte enables;
- runs a request/grant/response handshake on the bus;
- stalls the pipeline until the access finishes;
- returns sign- or zero-extended load data;
- flags misaligned accesses and bus timeouts.

---
 rtl/load_store_unit_if.sv | 16 +
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  input  bus_gnt, bus_rvalid, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  output bus_gnt, bus_rvalid, bus_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: store alignment, bus handshake with timeout,
// pipeline stall and sign/zero-extended load return.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  load_store_unit_if.master bus
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       width_q, addr_lo_q;
  logic             unsigned_q;
  logic             done_q, done_d, mis_q, mis_d, err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             bus_req_q, bus_req_d, bus_we_q;
  logic [31:0]      bus_addr_q, bus_wdata_q;
  logic [3:0]       bus_be_q;

  logic        access_c, misalign_c, capture_c, complete_c, timeout_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign access_c   = req_valid & (mem_read | mem_write);
  assign misalign_c = ((mem_width == 2'b01) & addr[0]) |
                      (mem_width[1] & (addr[1:0] != 2'b00));
  assign capture_c  = (state_q == S_IDLE) & access_c;
  // A write completes on grant; a read completes when its data arrives.
  assign complete_c = ((state_q == S_REQ) & bus.bus_gnt & (bus_we_q | bus.bus_rvalid)) |
                      ((state_q == S_WAIT) & bus.bus_rvalid);
  assign timeout_c  = ((state_q == S_REQ) | (state_q == S_WAIT)) &
                      (cnt_q == CNT_LAST) & ~complete_c;
  assign stall      = access_c & (state_q != S_DONE);

  // Store lane replication and byte enables
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (mem_width)
      2'b00: begin
        be_c    = 4'(4'b0001 << addr[1:0]);
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    byte_c = bus.bus_rdata[7:0];
    case (addr_lo_q)
      2'b01:   byte_c = bus.bus_rdata[15:8];
      2'b10:   byte_c = bus.bus_rdata[23:16];
      2'b11:   byte_c = bus.bus_rdata[31:24];
      default: ;
    endcase
    half_c = addr_lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    load_c = bus.bus_rdata;
    case (width_q)
      2'b00:   load_c = {{24{~unsigned_q & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{~unsigned_q & half_c[15]}}, half_c};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (access_c) state_d = misalign_c ? S_DONE : S_REQ;
      S_REQ: begin
        if (complete_c || timeout_c) state_d = S_DONE;
        else if (bus.bus_gnt)        state_d = S_WAIT;
      end
      S_WAIT:  if (complete_c || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rdata is rewritten on every completion: load data on a good read, else zero
  always_comb begin
    bus_req_d = (state_d == S_REQ);
    done_d    = (state_d == S_DONE);
    mis_d     = capture_c & misalign_c;
    err_d     = timeout_c;
    rdata_d   = rdata_q;
    if (state_d == S_DONE) rdata_d = (complete_c & ~bus_we_q) ? load_c : 32'h0;
    cnt_d = ((state_q == S_REQ) || (state_q == S_WAIT)) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      width_q     <= 2'b00;
      addr_lo_q   <= 2'b00;
      unsigned_q  <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'b0000;
    end else begin
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      bus_req_q <= bus_req_d;
      if (capture_c) begin
        width_q     <= mem_width;
        addr_lo_q   <= addr[1:0];
        unsigned_q  <= load_unsigned;
        bus_we_q    <= mem_write;
        bus_addr_q  <= {addr[31:2], 2'b00};
        bus_wdata_q <= wdata_c;
        bus_be_q    <= mem_write ? be_c : 4'b0000;
      end
    end
  end

  assign done          = done_q;
  assign misaligned    = mis_q;
  assign bus_err       = err_q;
  assign rdata         = rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a transaction-level reference model.
module tb_load_store_unit;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write, load_unsigned;
  logic [1:0]  mem_width;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] rdata;

  load_store_unit_if bus_if();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_width(mem_width), .load_unsigned(load_unsigned),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          obs_done, obs_reqc;
  logic [31:0] obs_stall, obs_rdata, obs_rdata_after, obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_mis, obs_err, obs_we, obs_done_after, obs_unstable;

  int          exp_done, exp_reqc;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_mis, exp_err, exp_we;

  // Transaction-level expectation: latency, bus image and result from the access rules
  task automatic model_txn(input logic wr, input logic [1:0] w, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                           input int glat, input int rlat);
    int size, r;
    logic [31:0] v;
    size      = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    exp_mis   = (a % size) != 0;
    exp_err   = 1'b0;
    exp_rdata = 32'h0;
    exp_we    = wr;
    exp_addr  = a & ~32'h3;
    exp_be    = !wr ? 4'h0 : (size == 4) ? 4'hF : (size == 2) ? 4'(3 << (a & 2)) : 4'(1 << (a % 4));
    exp_wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    if (exp_mis) begin
      exp_done = 1; exp_reqc = 0;
    end else if (glat < 0 || glat > int'(T) - 1) begin
      exp_done = 1 + int'(T); exp_reqc = int'(T); exp_err = 1'b1;
    end else begin
      exp_reqc = glat + 1;
      r = wr ? glat : glat + rlat;
      if (r <= int'(T) - 1) begin
        exp_done = r + 2;
        if (!wr) begin
          v = rw >> (8 * (a % 4));
          if (size == 1) begin v = v & 32'hFF;   if (!uns && v >= 32'd128)   v = v - 32'd256; end
          if (size == 2) begin v = v & 32'hFFFF; if (!uns && v >= 32'd32768) v = v - 32'd65536; end
          exp_rdata = v;
        end
      end else begin
        exp_done = 1 + int'(T); exp_err = 1'b1;
      end
    end
  endtask

  // Drives one access from its IDLE cycle (C0) while acting as the bus slave; records outputs
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                         input int glat, input int rlat, input bit noise);
    int granted_at, req_n;
    bit seen;
    granted_at = -1; req_n = 0; seen = 0;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_width = w;
    load_unsigned = uns; addr = a; wdata = wd; bus_if.bus_rdata = rw;
    obs_done = -1; obs_reqc = 0; obs_stall = '0; obs_unstable = 0; obs_rdata = 32'h0;
    obs_mis = 0; obs_err = 0; obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0;
    for (int k = 0; k < 24; k++) begin
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
      if (noise && k == 0) begin bus_if.bus_gnt = 1'b1; bus_if.bus_rvalid = 1'b1; end
      if (bus_if.bus_req) begin
        if (req_n == glat) begin
          bus_if.bus_gnt = 1'b1; granted_at = k; bus_if.bus_rvalid = (rlat == 0);
        end else if (noise) bus_if.bus_rvalid = 1'($urandom_range(0, 1));
        req_n++;
      end else if (granted_at >= 0 && k == granted_at + rlat) bus_if.bus_rvalid = 1'b1;
      @(negedge clk);
      obs_stall[k] = stall;
      if (bus_if.bus_req) begin
        obs_reqc++;
        if (!seen) begin
          seen = 1; obs_addr = bus_if.bus_addr; obs_wdata = bus_if.bus_wdata;
          obs_be = bus_if.bus_be; obs_we = bus_if.bus_we;
        end else if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_be, bus_if.bus_we} !==
                     {obs_addr, obs_wdata, obs_be, obs_we}) obs_unstable = 1;
      end
      if (done && obs_done < 0) begin
        obs_done = k; obs_rdata = rdata; obs_mis = misaligned; obs_err = bus_err;
      end
      @(posedge clk); #1;
      if (obs_done >= 0) break;
    end
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    obs_done_after = done; obs_rdata_after = rdata;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req_valid = 0; mem_read = 0; mem_write = 0; mem_width = 0;
    load_unsigned = 0; addr = 0; wdata = 0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({misaligned, bus_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {misaligned, bus_err}); end
    total++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'h0) begin bad++; $display("FAIL reset_busctl got=%h exp=0", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
    total++; if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'h0) begin bad++; $display("FAIL reset_busdata got=%h exp=0", {bus_if.bus_addr, bus_if.bus_wdata}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({stall, done, bus_if.bus_req} !== 3'b000) begin bad++; $display("FAIL reset_release got=%b exp=000", {stall, done, bus_if.bus_req}); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_load;
    run_txn(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8000_0000, 0, 1, 0);
    total++; if (obs_done !== 3) begin bad++; $display("FAIL lb_latency got=%0d exp=3", obs_done); end
    total++; if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
    total++; if ({obs_addr, obs_be} !== {32'h100, 4'h0}) begin bad++; $display("FAIL lb_bus got=%h/%h exp=100/0", obs_addr, obs_be); end
    total++; if (obs_stall !== 32'h7) begin bad++; $display("FAIL lb_stall got=%h exp=7", obs_stall); end
    idle(1);
    run_txn(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8000_0000, 0, 1, 0);
    total++; if (obs_rdata !== 32'h80) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rdata); end
    total++; if (obs_rdata_after !== 32'h80) begin bad++; $display("FAIL lbu_hold got=%h exp=00000080", obs_rdata_after); end
    idle(1);
  endtask

  task automatic test_half_store;
    run_txn(0, 1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 32'h0, 0, 1, 0);
    total++; if (obs_done !== 2) begin bad++; $display("FAIL sh_latency got=%0d exp=2", obs_done); end
    total++; if ({obs_be, obs_we} !== {4'b1100, 1'b1}) begin bad++; $display("FAIL sh_be_we got=%b exp=11001", {obs_be, obs_we}); end
    total++; if (obs_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    total++; if (obs_stall !== 32'h3) begin bad++; $display("FAIL sh_stall got=%h exp=3", obs_stall); end
    total++; if (obs_rdata !== 32'h0) begin bad++; $display("FAIL sh_rdata got=%h exp=0", obs_rdata); end
    idle(1);
  endtask

  task automatic test_word_same_cycle;
    run_txn(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    total++; if (obs_done !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", obs_done); end
    total++; if (obs_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rdata); end
    total++; if (obs_done_after !== 1'b0) begin bad++; $display("FAIL lw_done_pulse got=%b exp=0", obs_done_after); end
    idle(1);
  endtask

  task automatic test_misaligned;
    run_txn(1, 0, 2'b10, 0, 32'h41, 32'h0, 32'h5555_5555, 0, 0, 0);
    total++; if ({obs_done, obs_reqc} !== {32'd1, 32'd0}) begin bad++; $display("FAIL mis_latency_req got=%0d/%0d exp=1/0", obs_done, obs_reqc); end
    total++; if ({obs_mis, obs_err} !== 2'b10) begin bad++; $display("FAIL mis_flags got=%b exp=10", {obs_mis, obs_err}); end
    total++; if (obs_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", obs_rdata); end
    idle(1);
  endtask

  task automatic test_timeout;
    run_txn(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h1111_2222, -1, 0, 0);
    total++; if ({obs_done, obs_reqc} !== {32'd5, 32'd4}) begin bad++; $display("FAIL tmo_latency_req got=%0d/%0d exp=5/4", obs_done, obs_reqc); end
    total++; if ({obs_err, obs_mis} !== 2'b10) begin bad++; $display("FAIL tmo_flags got=%b exp=10", {obs_err, obs_mis}); end
    total++; if (obs_rdata !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%h exp=0", obs_rdata); end
    total++; if (obs_stall !== 32'h1F) begin bad++; $display("FAIL tmo_stall got=%h exp=1f", obs_stall); end
    idle(1);
    run_txn(0, 1, 2'b10, 0, 32'h48, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
    total++; if ({obs_done, obs_err} !== {32'd2, 1'b0}) begin bad++; $display("FAIL tmo_recover got=%0d/%b exp=2/0", obs_done, obs_err); end
    idle(1);
  endtask

  task automatic test_no_access;
    for (int k = 0; k < 4; k++) begin
      req_valid = k[0]; mem_read = ~k[0]; mem_write = 1'b0; addr = 32'h41;
      @(negedge clk);
      total++; if ({stall, done, bus_if.bus_req} !== 3'b000) begin bad++; $display("FAIL noacc_%0d got=%b exp=000", k, {stall, done, bus_if.bus_req}); end
      @(posedge clk); #1;
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    run_txn(0, 1, 2'b00, 0, 32'h301, 32'h0000_00A5, 32'h0, 0, 0, 0);
    total++; if ({obs_be, obs_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin bad++; $display("FAIL b2b_store got=%h/%h exp=2/a5a5a5a5", obs_be, obs_wdata); end
    run_txn(1, 0, 2'b01, 0, 32'h302, 32'h0, 32'h8001_7FFF, 1, 1, 0);
    total++; if (obs_done !== 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", obs_done); end
    total++; if (obs_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL b2b_rdata got=%h exp=ffff8001", obs_rdata); end
    idle(1);
  endtask

  task automatic test_random;
    logic rd, wr, uns;
    logic [1:0] w;
    logic [31:0] a, wd, rw;
    int glat, rlat, op;
    bit noise;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 2));
      rd = (op != 1); wr = (op != 0);
      w = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; rw = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0 && w[1]) a[1] = 1'b0;
      glat = int'($urandom_range(0, 5)); if (glat == 5) glat = -1;
      rlat = int'($urandom_range(0, 3));
      noise = 1'($urandom_range(0, 1));
      model_txn(wr, w, uns, a, wd, rw, glat, rlat);
      run_txn(rd, wr, w, uns, a, wd, rw, glat, rlat, noise);
      total++; if (obs_done !== exp_done) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, obs_done, exp_done); end
      total++; if (obs_rdata !== exp_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, obs_rdata, exp_rdata); end
      total++; if ({obs_mis, obs_err} !== {exp_mis, exp_err}) begin bad++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, {obs_mis, obs_err}, {exp_mis, exp_err}); end
      total++; if (obs_reqc !== exp_reqc) begin bad++; $display("FAIL rnd%0d_reqcycles got=%0d exp=%0d", i, obs_reqc, exp_reqc); end
      total++; if (obs_stall !== 32'((64'd1 << exp_done) - 64'd1)) begin bad++; $display("FAIL rnd%0d_stall got=%h exp_len=%0d", i, obs_stall, exp_done); end
      total++; if ({obs_done_after, obs_rdata_after} !== {1'b0, exp_rdata}) begin bad++; $display("FAIL rnd%0d_after got=%b/%h exp=0/%h", i, obs_done_after, obs_rdata_after, exp_rdata); end
      if (exp_reqc > 0) begin
        total++; if ({obs_addr, obs_we, obs_be} !== {exp_addr, exp_we, exp_be}) begin bad++; $display("FAIL rnd%0d_busctl got=%h/%b/%h exp=%h/%b/%h", i, obs_addr, obs_we, obs_be, exp_addr, exp_we, exp_be); end
        total++; if (obs_wdata !== exp_wdata) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, obs_wdata, exp_wdata); end
        total++; if (obs_unstable !== 1'b0) begin bad++; $display("FAIL rnd%0d_bus_stable got=%b exp=0", i, obs_unstable); end
      end
      if ($urandom_range(0, 1) != 0) idle(1);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    bit seen;
    req_valid = 1; mem_read = 1; mem_write = 0; mem_width = 2'b10; load_unsigned = 0;
    addr = 32'h80; wdata = 0; bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
    @(posedge clk); #1;
    total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL rstreq_before got=%b exp=1", bus_if.bus_req); end
    #2; rst_n = 1'b0; req_valid = 1'b0; #1;
    total++; if ({bus_if.bus_req, stall} !== 2'b00) begin bad++; $display("FAIL rstreq_after got=%b exp=00", {bus_if.bus_req, stall}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; req_valid = 1'b1;
    @(posedge clk); #1; bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1; bus_if.bus_gnt = 1'b0;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstwait_stall_before got=%b exp=1", stall); end
    #2; rst_n = 1'b0; req_valid = 1'b0; #1;
    total++; if ({bus_if.bus_req, stall, done} !== 3'b000) begin bad++; $display("FAIL rstwait_after got=%b exp=000", {bus_if.bus_req, stall, done}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(posedge clk); #1; bus_if.bus_rvalid = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstwait_late_rvalid got=%b exp=0", seen); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstwait_rdata got=%h exp=0", rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_word_same_cycle();
    test_misaligned();
    test_timeout();
    test_no_access();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
